zbuffer_depth_test: RTL and testbench

- Fragment-level depth-test stage sitting directly upstream of zbuffer_sram, instantiated with CHANNELS=2: channel 0 is read-only, channel 1 is write-only.
- Accepts fragments (address, depth, colour) over valid/ready, reads the stored depth, compares, writes back the new depth on pass, and forwards passing fragments downstream to the framebuffer writer.
- Also owns depth-buffer clear: a sweep writing CLEAR_DEPTH to every location.

---
 rtl/zbuffer_pkg.sv | 22 ++
 rtl/zbuffer_clear_sweep.sv | 44 ++++
 rtl/zbuffer_depth_test.sv | 202 ++++++++++++++++++++
 tb/tb_zbuffer_depth_test.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbuffer_pkg.sv
// Shared types and default widths for the zbuffer depth-test stage.
// Optional statistics counters are enabled with ZTEST_STATS_EN in zbuffer_depth_test.
package zbuffer_pkg;

    localparam int ZB_ADDR_SIZE  = 8;
    localparam int ZB_DEPTH_SIZE = 16;
    localparam int ZB_COLOR_SIZE = 16;
    localparam int ZB_SIZE       = 256;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } zb_state_t;

    typedef struct packed {
        logic [ZB_ADDR_SIZE-1:0]  addr;
        logic [ZB_DEPTH_SIZE-1:0] z;
        logic [ZB_COLOR_SIZE-1:0] color;
    } fragment_t;

endpackage

// File: rtl/zbuffer_clear_sweep.sv
// Address counter for the depth-buffer clear: counts 0..SIZE-1 while run is high,
// flags the final address and pulses done the cycle after it is written.
module zbuffer_clear_sweep #(
    parameter int ADDR_SIZE = 8,
    parameter int SIZE      = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic [ADDR_SIZE-1:0] cnt,
    output logic                 last,
    output logic                 done
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(SIZE - 1);

    logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        last   = run && (cnt_q == LAST_ADDR);
        cnt_d  = '0;
        if (run && !last) begin
            cnt_d = cnt_q + ADDR_SIZE'(1);
        end
        done_d = last;
    end

    // NOTE: state updates use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/zbuffer_depth_test.sv
// Fragment depth-test stage in front of a 2-port zbuffer_sram (port 0 read, port 1 write).
// Define ZTEST_STATS_EN to add pass_count/fail_count statistics outputs.
module zbuffer_depth_test
    import zbuffer_pkg::*;
#(
    parameter int                    ADDR_SIZE   = ZB_ADDR_SIZE,
    parameter int                    DEPTH_SIZE  = ZB_DEPTH_SIZE,
    parameter int                    COLOR_SIZE  = ZB_COLOR_SIZE,
    parameter int                    SIZE        = ZB_SIZE,
    parameter logic [DEPTH_SIZE-1:0] CLEAR_DEPTH = '1,
    parameter int                    LEQUAL      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_SIZE-1:0]  in_addr,
    input  logic [DEPTH_SIZE-1:0] in_z,
    input  logic [COLOR_SIZE-1:0] in_color,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_SIZE-1:0]  out_addr,
    output logic [COLOR_SIZE-1:0] out_color,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [ADDR_SIZE-1:0]  zb_rd_addr,
    input  logic [DEPTH_SIZE-1:0] zb_rd_data,
    output logic                  zb_we,
    output logic [ADDR_SIZE-1:0]  zb_wr_addr,
    output logic [DEPTH_SIZE-1:0] zb_wr_data
`ifdef ZTEST_STATS_EN
    ,
    output logic [31:0]           pass_count,
    output logic [31:0]           fail_count
`endif
);

    zb_state_t state_q, state_d;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_first_q, s1_first_d;
    logic [ADDR_SIZE-1:0]  s1_addr_q,  s1_addr_d;
    logic [DEPTH_SIZE-1:0] s1_z_q,     s1_z_d;
    logic [COLOR_SIZE-1:0] s1_color_q, s1_color_d;
    logic [DEPTH_SIZE-1:0] s1_zmem_q,  s1_zmem_d;

    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_SIZE-1:0]  fwd_addr_q,  fwd_addr_d;
    logic [DEPTH_SIZE-1:0] fwd_z_q,     fwd_z_d;

    logic                  accept, fwd_hit, s1_pass, s1_done;
    logic [DEPTH_SIZE-1:0] stored_z;

    logic                  sweep_run, sweep_last, sweep_done;
    logic [ADDR_SIZE-1:0]  sweep_cnt;

    assign sweep_run = (state_q == CLEAR);

    zbuffer_clear_sweep #(
        .ADDR_SIZE (ADDR_SIZE),
        .SIZE      (SIZE)
    ) u_sweep (
        .clk  (clk),
        .rst  (rst),
        .run  (sweep_run),
        .cnt  (sweep_cnt),
        .last (sweep_last),
        .done (sweep_done)
    );

    // The sram answers a same-cycle read/write with old data, so the last write is forwarded.
    always_comb begin
        fwd_hit  = fwd_valid_q && (fwd_addr_q == s1_addr_q);
        stored_z = s1_zmem_q;
        if (s1_first_q) begin
            stored_z = fwd_hit ? fwd_z_q : zb_rd_data;
        end
        s1_pass   = (LEQUAL != 0) ? (s1_z_q <= stored_z) : (s1_z_q < stored_z);
        out_valid = s1_valid_q && s1_pass;
        s1_done   = s1_valid_q && (!s1_pass || out_ready);
        in_ready  = !rst && (state_q == RUN) && (!s1_valid_q || s1_done);
        accept    = in_valid && in_ready;

        zb_rd_addr = accept ? in_addr : '0;
        out_addr   = out_valid ? s1_addr_q : '0;
        out_color  = out_valid ? s1_color_q : '0;
        clear_busy = (state_q != RUN);
        clear_done = sweep_done;

        zb_we      = 1'b0;
        zb_wr_addr = '0;
        zb_wr_data = '0;
        if (state_q == CLEAR) begin
            zb_we      = 1'b1;
            zb_wr_addr = sweep_cnt;
            zb_wr_data = CLEAR_DEPTH;
        end else if (s1_done && s1_pass) begin
            zb_we      = 1'b1;
            zb_wr_addr = s1_addr_q;
            zb_wr_data = s1_z_q;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_first_d = 1'b0;
        s1_addr_d  = s1_addr_q;
        s1_z_d     = s1_z_q;
        s1_color_d = s1_color_q;
        s1_zmem_d  = s1_first_q ? stored_z : s1_zmem_q;
        if (s1_done) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_first_d = 1'b1;
            s1_addr_d  = in_addr;
            s1_z_d     = in_z;
            s1_color_d = in_color;
        end

        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_z_d     = fwd_z_q;
        if (state_q == CLEAR) begin
            // The sweep overwrites everything, so a held forward value would be stale.
            fwd_valid_d = 1'b0;
        end else if (s1_done) begin
            fwd_valid_d = s1_pass;
            if (s1_pass) begin
                fwd_addr_d = s1_addr_q;
                fwd_z_d    = s1_z_q;
            end
        end

        state_d = state_q;
        case (state_q)
            RUN:     if (clear_start) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q) state_d = CLEAR;
            CLEAR:   if (sweep_last)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_z_q      <= '0;
            s1_color_q  <= '0;
            s1_zmem_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_z_q     <= '0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_addr_q   <= s1_addr_d;
            s1_z_q      <= s1_z_d;
            s1_color_q  <= s1_color_d;
            s1_zmem_q   <= s1_zmem_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_z_q     <= fwd_z_d;
        end
    end

`ifdef ZTEST_STATS_EN
    logic [31:0] pass_count_q, pass_count_d;
    logic [31:0] fail_count_q, fail_count_d;

    always_comb begin
        pass_count_d = pass_count_q;
        fail_count_d = fail_count_q;
        if (state_q == DRAIN && state_d == CLEAR) begin
            pass_count_d = '0;
            fail_count_d = '0;
        end else if (s1_done) begin
            if (s1_pass) pass_count_d = pass_count_q + 32'd1;
            else         fail_count_d = fail_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_count_q <= '0;
            fail_count_q <= '0;
        end else begin
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign pass_count = pass_count_q;
    assign fail_count = fail_count_q;
`endif

endmodule

// File: tb/tb_zbuffer_depth_test.sv
// Directed bench for zbuffer_depth_test: one instance with LEQUAL=0 (a) and one with LEQUAL=1 (b),
// each with its own behavioural read-first sram, driven by the same stimulus.
module tb_zbuffer_depth_test;
    import zbuffer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, clear_start;
    logic [7:0]  in_addr;
    logic [15:0] in_z, in_color;

    logic        in_ready_a, out_valid_a, clear_busy_a, clear_done_a, zb_we_a;
    logic [7:0]  out_addr_a, zb_rd_addr_a, zb_wr_addr_a;
    logic [15:0] out_color_a, zb_rd_data_a, zb_wr_data_a;
    logic        in_ready_b, out_valid_b, clear_busy_b, clear_done_b, zb_we_b;
    logic [7:0]  out_addr_b, zb_rd_addr_b, zb_wr_addr_b;
    logic [15:0] out_color_b, zb_rd_data_b, zb_wr_data_b;
`ifdef ZTEST_STATS_EN
    logic [31:0] pass_count_a, fail_count_a, pass_count_b, fail_count_b;
`endif

    zbuffer_depth_test #(.LEQUAL(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_addr(in_addr), .in_z(in_z), .in_color(in_color),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_addr(out_addr_a), .out_color(out_color_a),
        .clear_start(clear_start), .clear_busy(clear_busy_a), .clear_done(clear_done_a),
        .zb_rd_addr(zb_rd_addr_a), .zb_rd_data(zb_rd_data_a),
        .zb_we(zb_we_a), .zb_wr_addr(zb_wr_addr_a), .zb_wr_data(zb_wr_data_a)
`ifdef ZTEST_STATS_EN
        , .pass_count(pass_count_a), .fail_count(fail_count_a)
`endif
    );

    zbuffer_depth_test #(.LEQUAL(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_addr(in_addr), .in_z(in_z), .in_color(in_color),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_addr(out_addr_b), .out_color(out_color_b),
        .clear_start(clear_start), .clear_busy(clear_busy_b), .clear_done(clear_done_b),
        .zb_rd_addr(zb_rd_addr_b), .zb_rd_data(zb_rd_data_b),
        .zb_we(zb_we_b), .zb_wr_addr(zb_wr_addr_b), .zb_wr_data(zb_wr_data_b)
`ifdef ZTEST_STATS_EN
        , .pass_count(pass_count_b), .fail_count(fail_count_b)
`endif
    );

    // Read-first sram models: a same-edge write is not visible to the read.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;

    always @(posedge clk) begin
        zb_rd_data_a <= mem_a[zb_rd_addr_a];
        zb_rd_data_b <= mem_b[zb_rd_addr_b];
        if (zb_we_a) begin
            mem_a[zb_wr_addr_a] <= zb_wr_data_a;
            wr_cnt_a <= wr_cnt_a + 1;
        end
        if (zb_we_b) begin
            mem_b[zb_wr_addr_b] <= zb_wr_data_b;
            wr_cnt_b <= wr_cnt_b + 1;
        end
        if (clear_done_a) done_cnt_a <= done_cnt_a + 1;
        if (clear_done_b) done_cnt_b <= done_cnt_b + 1;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        fragment_t frag;
        logic      pass_a;
        logic      pass_b;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] a, input logic [15:0] z, input logic [15:0] c,
                                input logic pa, input logic pb);
        vec_t v;
        v.frag.addr  = a;
        v.frag.z     = z;
        v.frag.color = c;
        v.pass_a     = pa;
        v.pass_b     = pb;
        return v;
    endfunction

    vec_t vecs [7];
    int   good, wa, wb, dca;
    logic found;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_z = '0; in_color = '0;
        out_ready = 1'b1; clear_start = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        check("rst_in_ready",   32'(in_ready_a), 0);
        check("rst_out_valid",  32'(out_valid_a), 0);
        check("rst_zb_we",      32'(zb_we_a), 0);
        check("rst_clear_busy", 32'(clear_busy_a), 0);
        check("rst_clear_done", 32'(clear_done_a), 0);
        check("rst_wr_addr",    32'(zb_wr_addr_a), 0);
        check("rst_wr_data",    32'(zb_wr_data_a), 0);
        check("rst_out_addr",   32'(out_addr_a), 0);
        @(negedge clk); rst = 1'b0; #1;
        check("post_rst_ready", 32'(in_ready_a), 1);

        // Full clear; a second clear_start mid-sweep must be ignored
        clear_start = 1'b1;
        @(negedge clk); clear_start = 1'b0; #1;
        check("drain_busy",  32'(clear_busy_a), 1);
        check("drain_ready", 32'(in_ready_a), 0);
        check("drain_no_we", 32'(zb_we_a), 0);
        good = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); clear_start = (i == 50); #1;
            if (zb_we_a && zb_wr_addr_a == i[7:0] && zb_wr_data_a == 16'hFFFF &&
                clear_busy_a && !clear_done_a) good++;
        end
        check("clear_sweep_writes", 32'(good), 256);
        @(negedge clk); clear_start = 1'b0; #1;
        check("clear_done_pulse", 32'(clear_done_a), 1);
        check("clear_end_we",     32'(zb_we_a), 0);
        check("clear_end_ready",  32'(in_ready_a), 1);
        check("clear_end_busy",   32'(clear_busy_a), 0);
        @(negedge clk); #1;
        check("clear_done_low", 32'(clear_done_a), 0);
        check("clear_done_cnt", 32'(done_cnt_a), 1);
        check("clear_wr_cnt_a", 32'(wr_cnt_a), 256);
        check("clear_wr_cnt_b", 32'(wr_cnt_b), 256);
        good = 0;
        for (int i = 0; i < 256; i++) if (mem_a[i] == 16'hFFFF) good++;
        check("clear_mem_all", 32'(good), 256);
`ifdef ZTEST_STATS_EN
        check("stats_after_clear", pass_count_a + fail_count_a, 0);
`endif

        // Table: single fragments with an idle cycle between them
        vecs[0] = mk(8'd5,   16'h0100, 16'hA005, 1'b1, 1'b1);
        vecs[1] = mk(8'd5,   16'h0200, 16'hA105, 1'b0, 1'b0);
        vecs[2] = mk(8'd9,   16'h0400, 16'hA009, 1'b1, 1'b1);
        vecs[3] = mk(8'd9,   16'h0400, 16'hA109, 1'b0, 1'b1);
        vecs[4] = mk(8'd5,   16'h00FF, 16'hA205, 1'b1, 1'b1);
        vecs[5] = mk(8'd255, 16'hFFFE, 16'hA0FF, 1'b1, 1'b1);
        vecs[6] = mk(8'd0,   16'hFFFF, 16'hA000, 1'b0, 1'b1);
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            in_valid = 1'b1; in_addr = vecs[v].frag.addr; in_z = vecs[v].frag.z; in_color = vecs[v].frag.color;
            #1;
            check($sformatf("v%0d_in_ready_a", v), 32'(in_ready_a), 1);
            check($sformatf("v%0d_in_ready_b", v), 32'(in_ready_b), 1);
            wa = wr_cnt_a; wb = wr_cnt_b;
            @(negedge clk); in_valid = 1'b0; #1;
            check($sformatf("v%0d_out_valid_a", v), 32'(out_valid_a), 32'(vecs[v].pass_a));
            check($sformatf("v%0d_out_valid_b", v), 32'(out_valid_b), 32'(vecs[v].pass_b));
            check($sformatf("v%0d_we_a", v), 32'(zb_we_a), 32'(vecs[v].pass_a));
            if (vecs[v].pass_a) begin
                check($sformatf("v%0d_out_addr_a", v),  32'(out_addr_a),   32'(vecs[v].frag.addr));
                check($sformatf("v%0d_out_color_a", v), 32'(out_color_a),  32'(vecs[v].frag.color));
                check($sformatf("v%0d_wr_addr_a", v),   32'(zb_wr_addr_a), 32'(vecs[v].frag.addr));
                check($sformatf("v%0d_wr_data_a", v),   32'(zb_wr_data_a), 32'(vecs[v].frag.z));
            end
            if (vecs[v].pass_b) begin
                check($sformatf("v%0d_out_addr_b", v),  32'(out_addr_b),  32'(vecs[v].frag.addr));
                check($sformatf("v%0d_out_color_b", v), 32'(out_color_b), 32'(vecs[v].frag.color));
            end
            @(negedge clk); #1;
            check($sformatf("v%0d_out_idle_a", v), 32'(out_valid_a), 0);
            check($sformatf("v%0d_writes_a", v), 32'(wr_cnt_a - wa), 32'(vecs[v].pass_a));
            check($sformatf("v%0d_writes_b", v), 32'(wr_cnt_b - wb), 32'(vecs[v].pass_b));
        end

        // Back-to-back to addr 7: 0x300 and 0x200 pass, 0x250 must see forwarded 0x200
        @(negedge clk); in_valid = 1'b1; in_addr = 8'd7; in_z = 16'h0300; in_color = 16'hC001; #1;
        check("b2b_accept0", 32'(in_ready_a), 1);
        wa = wr_cnt_a;
        @(negedge clk); in_z = 16'h0200; in_color = 16'hC002; #1;
        check("b2b_out0_valid", 32'(out_valid_a), 1);
        check("b2b_out0_color", 32'(out_color_a), 32'h0000C001);
        check("b2b_wr0_data",   32'(zb_wr_data_a), 32'h00000300);
        check("b2b_accept1",    32'(in_ready_a), 1);
        @(negedge clk); in_z = 16'h0250; in_color = 16'hC003; #1;
        check("b2b_out1_valid", 32'(out_valid_a), 1);
        check("b2b_out1_color", 32'(out_color_a), 32'h0000C002);
        check("b2b_wr1_data",   32'(zb_wr_data_a), 32'h00000200);
        check("b2b_accept2",    32'(in_ready_a), 1);
        @(negedge clk); in_valid = 1'b0; #1;
        check("fwd_reject_a",    32'(out_valid_a), 0);
        check("fwd_reject_b",    32'(out_valid_b), 0);
        check("fwd_reject_we_a", 32'(zb_we_a), 0);
        @(negedge clk); #1;
        check("b2b_writes", 32'(wr_cnt_a - wa), 2);
        check("b2b_mem7",   32'(mem_a[7]), 32'h00000200);

        // Five-cycle downstream stall on a passing fragment
        @(negedge clk); in_valid = 1'b1; in_addr = 8'd20; in_z = 16'h0010; in_color = 16'h1234; out_ready = 1'b0; #1;
        check("stall_accept", 32'(in_ready_a), 1);
        wa = wr_cnt_a;
        good = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (out_valid_a && !in_ready_a && !zb_we_a && out_addr_a == 8'd20 && out_color_a == 16'h1234) good++;
        end
        check("stall_hold", 32'(good), 5);
        @(negedge clk); out_ready = 1'b1; #1;
        check("stall_release_valid", 32'(out_valid_a), 1);
        check("stall_release_we",    32'(zb_we_a), 1);
        check("stall_release_data",  32'(zb_wr_data_a), 32'h00000010);
        check("stall_release_ready", 32'(in_ready_a), 1);
        @(negedge clk); #1;
        check("stall_idle",   32'(out_valid_a), 0);
        check("stall_writes", 32'(wr_cnt_a - wa), 1);
        check("stall_mem20",  32'(mem_a[20]), 32'h00000010);
`ifdef ZTEST_STATS_EN
        check("stats_pass", pass_count_a, 7);
        check("stats_fail", fail_count_a, 4);
`endif

        // clear_start together with a fragment handshake, then reset at sweep address 100
        @(negedge clk); in_valid = 1'b1; in_addr = 8'd200; in_z = 16'h0005; in_color = 16'h0C0C; clear_start = 1'b1; #1;
        check("clr_frag_accept", 32'(in_ready_a), 1);
        @(negedge clk); in_valid = 1'b0; clear_start = 1'b0; #1;
        check("clr_frag_busy",  32'(clear_busy_a), 1);
        check("clr_frag_busy_b", 32'(clear_busy_b), 1);
        check("clr_frag_out",   32'(out_valid_a), 1);
        check("clr_frag_we",    32'(zb_we_a), 1);
        check("clr_frag_data",  32'(zb_wr_data_a), 32'h00000005);
        check("clr_frag_ready", 32'(in_ready_a), 0);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk); #1;
            if (zb_we_a && zb_wr_addr_a == 8'd100 && zb_wr_data_a == 16'hFFFF) found = 1'b1;
        end
        check("reached_cnt100", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rst_mid_we",    32'(zb_we_a), 0);
        check("rst_mid_busy",  32'(clear_busy_a), 0);
        check("rst_mid_ready", 32'(in_ready_a), 0);
`ifdef ZTEST_STATS_EN
        check("rst_mid_stats", pass_count_a + fail_count_a, 0);
`endif
        rst = 1'b0;
        wa = wr_cnt_a; dca = done_cnt_a;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
        end
        check("rst_no_writes",  32'(wr_cnt_a - wa), 0);
        check("rst_no_done",    32'(done_cnt_a - dca), 0);
        check("rst_no_done_b",  32'(done_cnt_b), 1);
        check("partial_mem20",  32'(mem_a[20]), 32'h0000FFFF);
        check("partial_mem200", 32'(mem_a[200]), 32'h00000005);
        check("partial_mem255", 32'(mem_a[255]), 32'h0000FFFE);
        check("partial_mem_b",  32'(mem_b[255]), 32'h0000FFFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
